oam_dma_ctrl: RTL and testbench

Sprite-DMA controller and system-bus arbiter for the 2A03 core. It sits between the CPU's bus outputs and the system bus. A CPU write to the DMA register starts a transfer. The block then halts the CPU and owns the bus, copying 256 bytes from a 256-byte page to the PPU OAM data port. Afterwards it returns the bus to the CPU.

---
 rtl/oam_dma_ctrl_pkg.sv | 19 +
 rtl/oam_dma_ctrl_if.sv | 21 ++
 rtl/oam_dma_bus_mux.sv | 26 ++
 rtl/oam_dma_ctrl.sv | 70 +++++++
 tb/tb_oam_dma_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// oam_dma_ctrl_pkg: shared state encodings, CPU control constants and address defaults.
// OAM_DMA_ALIGN_EN selects whether the odd-parity ALIGN state is taken.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if: CPU-side and system-bus-side signals of the sprite DMA arbiter.
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_rw;

    modport master (
        output cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
        input  cpu_halt, bus_addr, bus_data_out, bus_rw
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
        output cpu_halt, bus_addr, bus_data_out, bus_rw
    );
endinterface

// File: rtl/oam_dma_bus_mux.sv
// oam_dma_bus_mux: selects the system bus drive from the CPU or the DMA engine by state.
module oam_dma_bus_mux
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
    input  state_t      state,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    input  logic [7:0]  page,
    input  logic [7:0]  idx,
    input  logic [7:0]  data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_rw
);

    // DMA owns the bus in READ/WRITE; ALIGN forces a dummy read of the held CPU address
    always_comb begin
        bus_addr     = state == READ ? {page, idx} : state == WRITE ? DEST_ADDR : cpu_addr;
        bus_data_out = state == WRITE ? data : cpu_data_out;
        bus_rw       = state == WRITE ? RW_WRITE : (state == READ || state == ALIGN) ? RW_READ : cpu_rw;
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA controller; halts the CPU and copies a 256-byte page to OAM.
// Build with OAM_DMA_ALIGN_EN defined to add the odd-parity ALIGN cycle.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF
) (
    input  logic             clock,
    input  logic             nreset,
    oam_dma_ctrl_if.slave    sys,
    output logic             dma_active
);

    state_t      state, next_state;
    logic [7:0]  page, idx, data;
    logic        parity;
    logic        trigger;

    assign trigger    = state == IDLE && sys.cpu_addr == DMA_REG_ADDR && sys.cpu_rw == RW_WRITE;
    assign dma_active = state != IDLE;

    // next state and CPU halt; a CPU write in HALT is let through before stealing the bus
    always_comb begin
        next_state   = state;
        sys.cpu_halt = !(state == IDLE || (state == HALT && sys.cpu_rw == RW_WRITE));
        unique case (state)
            IDLE:    next_state = trigger ? HALT : IDLE;
            HALT:    next_state = sys.cpu_rw == RW_WRITE ? HALT : (ALIGN_EN && parity) ? ALIGN : READ;
            ALIGN:   next_state = READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = idx == 8'hFF ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    // state, source page, byte index, data latch and free-running parity
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            data   <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= next_state;
            parity <= ~parity;
            if (trigger) begin
                page <= sys.cpu_data_out;
                idx  <= 8'h00;
            end
            if (state == READ) data <= sys.bus_data_in;
            if (state == WRITE) idx <= idx + 8'd1;
        end
    end

    oam_dma_bus_mux #(.DEST_ADDR(DEST_ADDR)) u_mux (
        .state        (state),
        .cpu_addr     (sys.cpu_addr),
        .cpu_data_out (sys.cpu_data_out),
        .cpu_rw       (sys.cpu_rw),
        .page         (page),
        .idx          (idx),
        .data         (data),
        .bus_addr     (sys.bus_addr),
        .bus_data_out (sys.bus_data_out),
        .bus_rw       (sys.bus_rw)
    );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: self-checking bench for the sprite DMA controller.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic dma_active;
    logic mp;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } xfer_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        halt;
        logic        act;
        logic [15:0] ba;
        logic [7:0]  bd;
        logic        brw;
    } vec_t;

    xfer_t sb[$];

    oam_dma_ctrl_if bif();

    oam_dma_ctrl dut (
        .clock      (clock),
        .nreset     (nreset),
        .sys        (bif.slave),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    // memory model: each byte is a fixed function of its address
    assign bif.bus_data_in = bif.bus_addr[7:0] ^ bif.bus_addr[15:8] ^ 8'h3C;

    // reference parity flop
    always @(posedge clock or negedge nreset) begin
        if (!nreset) mp <= 1'b0;
        else mp <= ~mp;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clock);
        bif.cpu_addr     = a;
        bif.cpu_data_out = d;
        bif.cpu_rw       = rw;
        #1;
    endtask

    task automatic push_xfer(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) begin
            xfer_t e;
            e.addr = {pg, 8'(i)};
            e.data = 8'(i) ^ pg ^ 8'h3C;
            sb.push_back(e);
        end
    endtask

    task automatic trigger(input logic [7:0] pg, input bit exit_par);
        for (int k = 0; k < 4; k++) begin
            drive(16'h0000, 8'h00, 1'b1);
            if (mp == exit_par) break;
        end
        drive(16'h4014, pg, 1'b0);
        chk("trig_active", 32'(dma_active), 32'd0);
        push_xfer(pg);
    endtask

    task automatic run_xfer();
        int          halted = 0;
        int          dummy = 0;
        bit          exit_par = 1'b0;
        bit          done = 1'b0;
        logic [15:0] last_rd = 16'h0000;
        xfer_t       e;
        for (int c = 0; c < 700 && !done; c++) begin
            drive(16'h8123, 8'h00, 1'b1);
            if (c == 0) exit_par = mp;
            if (bif.cpu_halt) begin
                halted++;
                if (bif.bus_rw && bif.bus_addr == 16'h8123) dummy++;
                else if (bif.bus_rw) last_rd = bif.bus_addr;
                else begin
                    chk("wr_addr", 32'(bif.bus_addr), 32'h2004);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_write: got data %0h expected none", bif.bus_data_out);
                    end else begin
                        e = sb.pop_front();
                        chk("rd_addr", 32'(last_rd), 32'(e.addr));
                        chk("wr_data", 32'(bif.bus_data_out), 32'(e.data));
                    end
                end
            end else if (c > 0) begin
                done = 1'b1;
                chk("resume_addr", 32'(bif.bus_addr), 32'h8123);
                chk("resume_active", 32'(dma_active), 32'd0);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout: got still halted expected release");
        end
        chk("halted", 32'(halted), 32'(513 + int'(ALIGN_ON && exit_par)));
        chk("dummy_reads", 32'(dummy), 32'(1 + int'(ALIGN_ON && exit_par)));
        chk("sb_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        vec_t tv[5];
        bit   found;
        int   halts, wr2004;
        bif.cpu_addr     = 16'h1234;
        bif.cpu_data_out = 8'h5A;
        bif.cpu_rw       = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_halt", 32'(bif.cpu_halt), 32'd0);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_bus_addr", 32'(bif.bus_addr), 32'h1234);
        chk("rst_bus_data", 32'(bif.bus_data_out), 32'h5A);
        chk("rst_bus_rw", 32'(bif.bus_rw), 32'd0);
        @(negedge clock);
        bif.cpu_rw = 1'b1;
        nreset = 1'b1;

        // read of the DMA register, write elsewhere, trigger, then two pass-through writes
        tv[0] = '{16'h4014, 8'h00, 1'b1, 1'b0, 1'b0, 16'h4014, 8'h00, 1'b1};
        tv[1] = '{16'h4015, 8'h05, 1'b0, 1'b0, 1'b0, 16'h4015, 8'h05, 1'b0};
        tv[2] = '{16'h4014, 8'h02, 1'b0, 1'b0, 1'b0, 16'h4014, 8'h02, 1'b0};
        tv[3] = '{16'h4014, 8'h07, 1'b0, 1'b0, 1'b1, 16'h4014, 8'h07, 1'b0};
        tv[4] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 16'h0300, 8'h11, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(tv[i].a, tv[i].d, tv[i].rw);
            chk($sformatf("v%0d_halt", i), 32'(bif.cpu_halt), 32'(tv[i].halt));
            chk($sformatf("v%0d_active", i), 32'(dma_active), 32'(tv[i].act));
            chk($sformatf("v%0d_bus_addr", i), 32'(bif.bus_addr), 32'(tv[i].ba));
            chk($sformatf("v%0d_bus_data", i), 32'(bif.bus_data_out), 32'(tv[i].bd));
            chk($sformatf("v%0d_bus_rw", i), 32'(bif.bus_rw), 32'(tv[i].brw));
        end
        push_xfer(8'h02);
        run_xfer();

        trigger(8'h05, 1'b0);
        run_xfer();
        trigger(8'h0A, 1'b1);
        run_xfer();

        // reset during the READ of index 0x64
        trigger(8'h03, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 700; c++) begin
            drive(16'h8123, 8'h00, 1'b1);
            if (bif.bus_rw && bif.bus_addr == 16'h0364) begin
                found = 1'b1;
                break;
            end
        end
        chk("hit_idx64", 32'(found), 32'd1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_halt", 32'(bif.cpu_halt), 32'd0);
        chk("mid_rst_active", 32'(dma_active), 32'd0);
        chk("mid_rst_bus_addr", 32'(bif.bus_addr), 32'h8123);
        chk("mid_rst_bus_rw", 32'(bif.bus_rw), 32'd1);
        sb.delete();
        @(negedge clock);
        nreset = 1'b1;
        halts  = 0;
        wr2004 = 0;
        for (int c = 0; c < 600; c++) begin
            drive(16'h8123, 8'h00, 1'b1);
            if (bif.cpu_halt) halts++;
            if (!bif.bus_rw && bif.bus_addr == 16'h2004) wr2004++;
        end
        chk("post_rst_halts", 32'(halts), 32'd0);
        chk("post_rst_writes", 32'(wr2004), 32'd0);

        drive(16'h4015, 8'h05, 1'b0);
        chk("final_active", 32'(dma_active), 32'd0);
        drive(16'h0000, 8'h00, 1'b1);
        chk("final_active2", 32'(dma_active), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
